// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial adder: FSM state encoding, nibble width
// and the operand-width legality check.
package nibble_serial_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } nsa_state_t;

    function automatic bit width_ok(input int w);
        return (w >= NIB_W) && ((w % NIB_W) == 0);
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4.sv
// 4-bit carry-lookahead slice: nibble sum, carry-out and block propagate/generate.
module nibble_serial_adder_cla4
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout,
    output logic             pb,
    output logic             gb
);

    logic [NIB_W-1:0] p;
    logic [NIB_W-1:0] g;
    logic [NIB_W:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign gb = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
    assign pb = &p;

    assign c[4] = gb | (pb & cin);

    assign s    = p ^ c[NIB_W-1:0];
    assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that streams operands through one 4-bit CLA slice, low nibble first.
// Define NSA_GROUP_PG_EN to add the accumulated group propagate/generate outputs.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef NSA_GROUP_PG_EN
    ,
    output logic             grp_p,
    output logic             grp_g
`endif
);

    localparam int N     = WIDTH / NIB_W;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    generate
        if (!width_ok(WIDTH)) begin : g_width_chk
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    nsa_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry_q;

    logic [NIB_W-1:0] slice_s;
    logic             slice_co;
    logic [WIDTH+NIB_W-1:0] sum_ext;

    // Slice result enters from the top so nibble k ends at sum[4k+3:4k] after N shifts.
    assign sum_ext = {slice_s, sum_sh};

`ifdef NSA_GROUP_PG_EN
    logic slice_pb;
    logic slice_gb;
    logic grp_p_q;
    logic grp_g_q;

    nibble_serial_adder_cla4 u_cla4 (
        .a    (a_sh[NIB_W-1:0]),
        .b    (b_sh[NIB_W-1:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_co),
        .pb   (slice_pb),
        .gb   (slice_gb)
    );

    assign grp_p = grp_p_q;
    assign grp_g = grp_g_q;
`else
    nibble_serial_adder_cla4 u_cla4 (
        .a    (a_sh[NIB_W-1:0]),
        .b    (b_sh[NIB_W-1:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_co),
        .pb   (),
        .gb   ()
    );
`endif

    assign sum  = sum_sh;
    assign cout = carry_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry_q   <= 1'b0;
`ifdef NSA_GROUP_PG_EN
            grp_p_q   <= 1'b0;
            grp_g_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry_q  <= cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_RUN;
`ifdef NSA_GROUP_PG_EN
                        grp_p_q  <= 1'b1;
                        grp_g_q  <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    a_sh    <= a_sh >> NIB_W;
                    b_sh    <= b_sh >> NIB_W;
                    sum_sh  <= sum_ext[WIDTH+NIB_W-1:NIB_W];
                    carry_q <= slice_co;
`ifdef NSA_GROUP_PG_EN
                    grp_p_q <= grp_p_q & slice_pb;
                    grp_g_q <= slice_gb | (slice_pb & grp_g_q);
`endif
                    if (cnt == CNT_LAST) begin
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed bench for nibble_serial_adder at WIDTH=16 against an
// arithmetic reference model.
module tb_nibble_serial_adder;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef NSA_GROUP_PG_EN
    logic         grp_p;
    logic         grp_g;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef NSA_GROUP_PG_EN
        ,
        .grp_p     (grp_p),
        .grp_g     (grp_g)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: full-precision sum; bit W is the carry-out.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        check("idle_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input int hold);
        logic [W:0] exp;
        int         lat;
        exp = ref_sum(ta, tb_v, tc);
        wait_ready();
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        check("accept_busy", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'(N));
        check("sum", 32'(sum), 32'(exp[W-1:0]));
        check("cout", 32'(cout), 32'(exp[W]));
`ifdef NSA_GROUP_PG_EN
        check("grp_p", 32'(grp_p), 32'((ta ^ tb_v) == {W{1'b1}}));
        check("grp_g", 32'(grp_g), 32'(ref_sum(ta, tb_v, 1'b0) >> W));
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            tick();
            check("hold", {13'd0, in_ready, out_valid, exp}, {13'd0, 1'b0, 1'b1, exp});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("consumed", {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        logic [W:0] exp_q[$];
        logic [W:0] exp_v;
        int         cyc, last_acc, n_acc, n_res;
        logic       acc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (3) tick();
        check("rst_state", {13'd0, in_ready, out_valid, cout, sum}, {13'd0, 1'b1, 1'b0, 1'b0, 16'h0});
        rst_n = 1'b1;
        tick();

        run_op(16'h1234, 16'h4321, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 0);
        run_op(16'hA5A5, 16'h5A5A, 1'b1, 6);

        // Reset during the second RUN cycle discards the operation.
        wait_ready();
        a = 16'h8888; b = 16'h7777; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst", {13'd0, in_ready, out_valid, cout, sum}, {13'd0, 1'b1, 1'b0, 1'b0, 16'h0});
        rst_n = 1'b1;
        tick();
        run_op(16'h0003, 16'h0004, 1'b0, 0);

        for (int i = 0; i < 8; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        // Back-to-back stream: in_valid and out_ready held high.
        wait_ready();
        cyc = 0; last_acc = -1; n_acc = 0; n_res = 0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        out_ready = 1'b1;
        while (n_res < 200 && cyc < 2000) begin
            in_valid = (n_acc < 200);
            acc = in_ready && in_valid;
            if (acc) exp_q.push_back(ref_sum(a, b, cin));
            tick();
            cyc++;
            if (acc) begin
                if (last_acc >= 0) check("ii", 32'(cyc - last_acc), 32'(N + 2));
                last_acc = cyc;
                n_acc++;
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("b2b_spurious", 32'd1, 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("b2b_result", 32'({cout, sum}), 32'(exp_v));
                end
                n_res++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_count", 32'(n_res), 32'd200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
